d5m_bayer_bin2x2: RTL and testbench
===================================

// Module: d5m_bayer_bin2x2
// PURPOSE
//  Downstream stage of the D5M capture controller. Consumes its 8-bit raw Bayer
//  pixel stream (valid/sop/eop, no backpressure) and averages each 2x2 Bayer quad
//  (R,G,G,B) into one 8-bit luminance pixel, giving a COLS/2 x LINES/2 frame.
//  Output is an Avalon-ST source with ready, buffered by a small FIFO.
// PARAMETERS
//  COLS        2592  input pixels per line (even)
//  LINES       1944  input lines per frame (even)
//  FIFO_DEPTH  16    output FIFO entries (power of 2)
// PORTS
//  clk            in   1   pixel clock (same domain as upstream controller)
//  rst            in   1   synchronous reset, active-high
//  in_valid       in   1   input pixel valid
//  in_data        in   8   input raw Bayer pixel
//  in_sop         in   1   first pixel of frame (qualified by in_valid)
//  in_eop         in   1   last pixel of frame (qualified by in_valid)
//  out_ready      in   1   downstream ready
//  out_valid      out  1   output pixel valid
//  out_data       out  8   binned pixel
//  out_sop        out  1   first binned pixel of frame
//  out_eop        out  1   last binned pixel of frame
//  clear_status   in   1   clears sticky flags
//  overflow       out  1   sticky: result dropped, FIFO full
//  frame_err      out  1   sticky: sop/eop inconsistent with COLS x LINES
// BEHAVIOUR
//  - Reset: all outputs 0, FIFO empty, state WAIT_SOP, col=row=0.
//  - FSM WAIT_SOP: ignore beats until in_valid&in_sop -> ACTIVE, beat is col0,row0.
//    ACTIVE: each in_valid beat advances col (0..COLS-1), wraps to 0 and increments row.
//  - in_valid&in_sop while ACTIVE: restart at col0,row0 on that beat; set frame_err
//    unless previous frame completed.
//  - in_eop on beat other than (COLS-1,LINES-1): set frame_err, discard partial
//    frame, -> WAIT_SOP. Last beat without in_eop: output eop still emitted,
//    set frame_err, -> WAIT_SOP. Correct last beat -> WAIT_SOP, no error.
//  - Even row: pair sum p = d[2k]+d[2k+1] (9 bit, held d[2k] in a reg) written to
//    line buffer addr k on odd col. Line buffer: COLS/2 x 9 bit, 1-cycle read.
//  - Odd row: read addr k issued on even col; on odd col
//    s = buf[k] + d[2k] + d[2k+1] (10 bit), result = s[9:2] (truncate, no rounding).
//  - Result registered then pushed to FIFO with sop=(row==1&&k==0),
//    eop=(row==LINES-1&&k==COLS/2-1). Latency: out_valid 2 cycles after the odd-row
//    odd-col input beat (FIFO empty).
//  - FIFO: out_valid = !empty; pop on out_valid&out_ready; push and pop same cycle
//    legal when full. Push while full and no pop: result dropped, overflow set.
//  - clear_status clears flags; a flag event in the same cycle wins (flag stays 1).
//  - rst mid-frame: FIFO flushed, counters cleared, WAIT_SOP; next frame starts clean.
// STRUCTURE
//  - d5m_pkg: default COLS/LINES, FSM state encoding, COL_W/ROW_W via $clog2.
//  - Sub-module d5m_stream_fifo (sync FIFO, 10-bit word {sop,eop,data}, full/empty).
//  - Line buffer inferred in this module as simple dual-port RAM.
// TESTING (bench params COLS=4, LINES=4, FIFO_DEPTH=4 unless noted)
//  1 Rows 10,20,30,40 / 50,60,70,80 / 0,0,0,0 / 255x4, out_ready=1
//    -> out 35(sop),55,127,127(eop); 127=(0+0+255+255)>>2.
//  2 Same frame, out_ready=0 whole frame, FIFO_DEPTH=2 -> first 2 kept, overflow=1;
//    clear_status -> overflow=0.
//  3 in_eop on beat 6 of 16 -> frame_err=1, no out_eop; next clean frame binned
//    correctly.
//  4 in_sop at beat 9 mid-frame -> frame_err=1, counters restart, new frame output ok.
//  5 Beats before first sop ignored; rst asserted mid-frame -> out_valid=0 next
//    cycle, flags 0.
//  6 Random out_ready toggling, COLS=8,LINES=6, random data -> scoreboard matches
//    reference model, no overflow with FIFO_DEPTH=16.

Source files
------------

// File: rtl/d5m_pkg.sv
// rtl/d5m_pkg.sv - shared defaults, FSM encoding and FIFO word layout for the Bayer 2x2 binner
package d5m_pkg;
  localparam int DEF_COLS       = 2592;
  localparam int DEF_LINES      = 1944;
  localparam int DEF_FIFO_DEPTH = 16;
  localparam int DEF_COL_W      = $clog2(DEF_COLS);
  localparam int DEF_ROW_W      = $clog2(DEF_LINES);

  typedef enum logic {
    ST_WAIT_SOP = 1'b0,
    ST_ACTIVE   = 1'b1
  } state_t;

  typedef struct packed {
    logic       sop;
    logic       eop;
    logic [7:0] data;
  } pix_word_t;

  // Index width that never collapses to zero for tiny depths.
  function automatic int addr_bits(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction
endpackage

// File: rtl/d5m_bayer_bin2x2_if.sv
// rtl/d5m_bayer_bin2x2_if.sv - raw Bayer input stream and binned Avalon-ST output stream
interface d5m_bayer_bin2x2_if;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_sop;
  logic       in_eop;
  logic       out_ready;
  logic       out_valid;
  logic [7:0] out_data;
  logic       out_sop;
  logic       out_eop;

  modport master (
    output in_valid, in_data, in_sop, in_eop, out_ready,
    input  out_valid, out_data, out_sop, out_eop
  );

  modport slave (
    input  in_valid, in_data, in_sop, in_eop, out_ready,
    output out_valid, out_data, out_sop, out_eop
  );
endinterface

// File: rtl/d5m_stream_fifo.sv
// rtl/d5m_stream_fifo.sv - synchronous FIFO carrying {sop,eop,data} words
module d5m_stream_fifo
  import d5m_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int W     = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_push,
  input  logic [W-1:0] i_data,
  input  logic         i_pop,
  output logic [W-1:0] o_data,
  output logic         o_full,
  output logic         o_empty
);
  localparam int AW = addr_bits(DEPTH);
  localparam logic [AW:0] PTR_ONE = (AW + 1)'(1);

  logic [W-1:0] r_mem [DEPTH];
  logic [AW:0]  r_wptr;
  logic [AW:0]  r_rptr;
  logic         w_do_push;
  logic         w_do_pop;

  assign o_empty   = (r_wptr == r_rptr);
  assign o_full    = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
  assign w_do_pop  = i_pop && !o_empty;
  // When full, a push is still accepted if the head leaves in the same cycle.
  assign w_do_push = i_push && (!o_full || w_do_pop);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_do_push) r_wptr <= r_wptr + PTR_ONE;
      if (w_do_pop)  r_rptr <= r_rptr + PTR_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wptr[AW-1:0]] <= i_data;
  end

  assign o_data = r_mem[r_rptr[AW-1:0]];
endmodule

// File: rtl/d5m_bayer_bin2x2.sv
// rtl/d5m_bayer_bin2x2.sv - averages each 2x2 Bayer quad into one 8-bit pixel, FIFO-buffered output
module d5m_bayer_bin2x2
  import d5m_pkg::*;
#(
  parameter int COLS       = DEF_COLS,
  parameter int LINES      = DEF_LINES,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
  input  logic              clk,
  input  logic              rst,
  d5m_bayer_bin2x2_if.slave bus,
  input  logic              clear_status,
  output logic              overflow,
  output logic              frame_err
);
  localparam int COL_W  = $clog2(COLS);
  localparam int ROW_W  = $clog2(LINES);
  localparam int HALF   = COLS / 2;
  localparam int ADDR_W = COL_W - 1;
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(COLS - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(LINES - 1);

  state_t            r_state, w_state_nxt;
  logic [COL_W-1:0]  r_col, w_col;
  logic [ROW_W-1:0]  r_row, w_row;
  logic              w_start, w_accept, w_is_last, w_eop_err, w_frame_done, w_err_evt;
  logic [7:0]        r_hold;
  logic [8:0]        r_lbuf [HALF];
  logic [8:0]        r_rd;
  logic [8:0]        w_pair;
  logic [9:0]        w_sum;
  logic [ADDR_W-1:0] w_addr;
  logic              r_res_valid;
  pix_word_t         r_res, w_fifo_out;
  logic              w_full, w_empty, w_pop, w_ovf_evt;
  logic              r_overflow, r_frame_err;

  // A sop beat is always column 0 / row 0, whatever the counters held.
  assign w_start      = bus.in_valid && bus.in_sop;
  assign w_accept     = bus.in_valid && (bus.in_sop || r_state == ST_ACTIVE);
  assign w_col        = w_start ? '0 : r_col;
  assign w_row        = w_start ? '0 : r_row;
  assign w_is_last    = (w_col == COL_LAST) && (w_row == ROW_LAST);
  assign w_eop_err    = w_accept && bus.in_eop && !w_is_last;
  assign w_frame_done = w_accept && (w_is_last || bus.in_eop);
  assign w_err_evt    = (w_start && r_state == ST_ACTIVE) || w_eop_err ||
                        (w_accept && w_is_last && !bus.in_eop);

  always_comb begin
    w_state_nxt = r_state;
    if (w_accept) w_state_nxt = w_frame_done ? ST_WAIT_SOP : ST_ACTIVE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_WAIT_SOP;
      r_col   <= '0;
      r_row   <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        if (w_frame_done) begin
          r_col <= '0;
          r_row <= '0;
        end else if (w_col == COL_LAST) begin
          r_col <= '0;
          r_row <= w_row + ROW_W'(1);
        end else begin
          r_col <= w_col + COL_W'(1);
          r_row <= w_row;
        end
      end
    end
  end

  // Even rows park pair sums in the line buffer; odd rows add their pair to it.
  assign w_addr = w_col[COL_W-1:1];
  assign w_pair = {1'b0, r_hold} + {1'b0, bus.in_data};
  assign w_sum  = {1'b0, r_rd} + {1'b0, w_pair};

  always_ff @(posedge clk) begin
    if (w_accept && !w_col[0]) begin
      r_hold <= bus.in_data;
      r_rd   <= r_lbuf[w_addr];
    end
  end

  always_ff @(posedge clk) begin
    if (w_accept && w_col[0] && !w_row[0]) r_lbuf[w_addr] <= w_pair;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_res_valid <= 1'b0;
      r_res       <= '0;
    end else begin
      r_res_valid <= w_accept && w_col[0] && w_row[0] && !w_eop_err;
      r_res.sop   <= (w_row == ROW_W'(1)) && (w_addr == '0);
      r_res.eop   <= w_is_last;
      r_res.data  <= 8'(w_sum >> 2);
    end
  end

  assign w_pop     = !w_empty && bus.out_ready;
  assign w_ovf_evt = r_res_valid && w_full && !bus.out_ready;

  d5m_stream_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (10)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (r_res_valid),
    .i_data  (r_res),
    .i_pop   (w_pop),
    .o_data  (w_fifo_out),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  // A new flag event outranks a simultaneous clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_overflow  <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      if (w_ovf_evt)         r_overflow <= 1'b1;
      else if (clear_status) r_overflow <= 1'b0;
      if (w_err_evt)         r_frame_err <= 1'b1;
      else if (clear_status) r_frame_err <= 1'b0;
    end
  end

  assign bus.out_valid = !w_empty;
  assign bus.out_data  = w_empty ? 8'd0 : w_fifo_out.data;
  assign bus.out_sop   = !w_empty && w_fifo_out.sop;
  assign bus.out_eop   = !w_empty && w_fifo_out.eop;
  assign overflow      = r_overflow;
  assign frame_err     = r_frame_err;
endmodule

// File: tb/tb_d5m_bayer_bin2x2.sv
// tb/tb_d5m_bayer_bin2x2.sv - self-checking bench for d5m_bayer_bin2x2 (three parameter sets)
module tb_d5m_bayer_bin2x2;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0, in_sop = 1'b0, in_eop = 1'b0;
  logic       out_ready = 1'b0, clear_status = 1'b0;
  logic [7:0] in_data = 8'd0;
  logic       ovf_a, ovf_b, ovf_c, ferr_a, ferr_b, ferr_c;

  int n_chk = 0;
  int n_fail = 0;
  int sel = 0;
  bit sb_en = 1'b0;
  bit gaps = 1'b0;
  bit rnd_ready = 1'b0;

  logic [7:0] frame_px [64];
  logic [9:0] exp_q [$];
  logic [9:0] got_q [$];

  always #5 clk = ~clk;

  d5m_bayer_bin2x2_if ifa ();
  d5m_bayer_bin2x2_if ifb ();
  d5m_bayer_bin2x2_if ifc ();

  assign ifa.in_valid = in_valid;  assign ifb.in_valid = in_valid;  assign ifc.in_valid = in_valid;
  assign ifa.in_data  = in_data;   assign ifb.in_data  = in_data;   assign ifc.in_data  = in_data;
  assign ifa.in_sop   = in_sop;    assign ifb.in_sop   = in_sop;    assign ifc.in_sop   = in_sop;
  assign ifa.in_eop   = in_eop;    assign ifb.in_eop   = in_eop;    assign ifc.in_eop   = in_eop;
  assign ifa.out_ready = out_ready; assign ifb.out_ready = out_ready; assign ifc.out_ready = out_ready;

  d5m_bayer_bin2x2 #(.COLS(4), .LINES(4), .FIFO_DEPTH(4)) u_a (
    .clk(clk), .rst(rst), .bus(ifa), .clear_status(clear_status), .overflow(ovf_a), .frame_err(ferr_a));
  d5m_bayer_bin2x2 #(.COLS(4), .LINES(4), .FIFO_DEPTH(2)) u_b (
    .clk(clk), .rst(rst), .bus(ifb), .clear_status(clear_status), .overflow(ovf_b), .frame_err(ferr_b));
  d5m_bayer_bin2x2 #(.COLS(8), .LINES(6), .FIFO_DEPTH(16)) u_c (
    .clk(clk), .rst(rst), .bus(ifc), .clear_status(clear_status), .overflow(ovf_c), .frame_err(ferr_c));

  logic       o_valid, o_sop, o_eop, o_ovf, o_ferr;
  logic [7:0] o_data;

  always_comb begin
    {o_valid, o_sop, o_eop, o_data, o_ovf, o_ferr} =
      {ifa.out_valid, ifa.out_sop, ifa.out_eop, ifa.out_data, ovf_a, ferr_a};
    if (sel == 1)
      {o_valid, o_sop, o_eop, o_data, o_ovf, o_ferr} =
        {ifb.out_valid, ifb.out_sop, ifb.out_eop, ifb.out_data, ovf_b, ferr_b};
    else if (sel == 2)
      {o_valid, o_sop, o_eop, o_data, o_ovf, o_ferr} =
        {ifc.out_valid, ifc.out_sop, ifc.out_eop, ifc.out_data, ovf_c, ferr_c};
  end

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
    end
  endtask

  // Reference model: frame kept as a 2D pixel array, quad averaged when its last pixel arrives.
  int         pix [8][8];
  bit         m_active = 1'b0;
  bit         m_ferr = 1'b0;
  int         m_col = 0, m_row = 0;
  int         mc, mr, mcols, mlines, qsum;
  bit         mlast, mev;
  logic [7:0] avg;
  logic [9:0] e_w;

  always @(negedge clk) begin
    if (!rst) begin
      if (o_valid && out_ready) begin
        got_q.push_back({o_sop, o_eop, o_data});
        if (sb_en) begin
          if (exp_q.size() == 0) chk("sb_unexpected_output", int'({o_sop, o_eop, o_data}), -1);
          else begin
            e_w = exp_q.pop_front();
            chk("sb_word", int'({o_sop, o_eop, o_data}), int'(e_w));
          end
        end
      end
      if (sb_en) begin
        chk("sb_frame_err", int'(o_ferr), int'(m_ferr));
        chk("sb_overflow", int'(o_ovf), 0);
      end
    end
    mcols  = (sel == 2) ? 8 : 4;
    mlines = (sel == 2) ? 6 : 4;
    if (rst) begin
      exp_q.delete();
      m_active = 1'b0; m_ferr = 1'b0; m_col = 0; m_row = 0;
    end else begin
      mev = 1'b0;
      if (in_valid && (in_sop || m_active)) begin
        if (in_sop) begin
          if (m_active) mev = 1'b1;
          mc = 0; mr = 0;
        end else begin
          mc = m_col; mr = m_row;
        end
        mlast = (mc == mcols - 1) && (mr == mlines - 1);
        pix[mr][mc] = int'(in_data);
        if (in_eop && !mlast) begin
          mev = 1'b1; m_active = 1'b0; m_col = 0; m_row = 0;
        end else begin
          if ((mr % 2 == 1) && (mc % 2 == 1)) begin
            qsum = pix[mr-1][mc-1] + pix[mr-1][mc] + pix[mr][mc-1] + pix[mr][mc];
            avg = 8'(qsum / 4);
            exp_q.push_back({(mr == 1 && mc == 1), mlast, avg});
          end
          if (mlast) begin
            if (!in_eop) mev = 1'b1;
            m_active = 1'b0; m_col = 0; m_row = 0;
          end else begin
            m_active = 1'b1;
            m_col = (mc + 1) % mcols;
            m_row = (mc == mcols - 1) ? mr + 1 : mr;
          end
        end
      end
      if (mev) m_ferr = 1'b1;
      else if (clear_status) m_ferr = 1'b0;
    end
  end

  task automatic step();
    if (rnd_ready) out_ready = 1'($urandom_range(0, 1));
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; in_valid = 1'b0; in_sop = 1'b0; in_eop = 1'b0; clear_status = 1'b0;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic send_frame(input int n, input int eop_at);
    for (int i = 0; i < n; i++) begin
      if (gaps && $urandom_range(0, 3) == 0) begin
        in_valid = 1'b0; in_sop = 1'b0; in_eop = 1'b0;
        step();
      end
      in_valid = 1'b1; in_data = frame_px[i]; in_sop = (i == 0); in_eop = (i == eop_at);
      step();
    end
    in_valid = 1'b0; in_sop = 1'b0; in_eop = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 400 && exp_q.size() != 0; i++) step();
    chk("drain_empty", exp_q.size(), 0);
    step();
    step();
  endtask

  task automatic load_t1();
    for (int c = 0; c < 4; c++) begin
      frame_px[c]      = 8'(10 + 10 * c);
      frame_px[4 + c]  = 8'(50 + 10 * c);
      frame_px[8 + c]  = 8'd0;
      frame_px[12 + c] = 8'd255;
    end
  endtask

  initial begin
    do_reset();
    chk("reset_out_valid", int'(ifa.out_valid), 0);
    chk("reset_out_data", int'(ifa.out_data), 0);
    chk("reset_overflow", int'(ovf_a), 0);
    chk("reset_frame_err", int'(ferr_a), 0);

    // Basic frame, always ready
    sb_en = 1'b1; out_ready = 1'b1; got_q.delete();
    load_t1();
    send_frame(16, 15);
    drain();
    chk("t1_count", got_q.size(), 4);
    if (got_q.size() == 4) begin
      chk("t1_out0", int'(got_q[0]), int'({1'b1, 1'b0, 8'd35}));
      chk("t1_out1", int'(got_q[1]), int'({1'b0, 1'b0, 8'd55}));
      chk("t1_out2", int'(got_q[2]), int'({1'b0, 1'b0, 8'd127}));
      chk("t1_out3", int'(got_q[3]), int'({1'b0, 1'b1, 8'd127}));
    end

    // Overflow with a 2-deep FIFO and no ready
    sb_en = 1'b0; sel = 1; out_ready = 1'b0;
    do_reset();
    send_frame(16, 15);
    step(); step(); step();
    chk("t2_overflow_set", int'(ovf_b), 1);
    chk("t2_valid_held", int'(ifb.out_valid), 1);
    got_q.delete();
    out_ready = 1'b1;
    step(); step(); step(); step();
    chk("t2_kept_count", got_q.size(), 2);
    if (got_q.size() == 2) begin
      chk("t2_kept0", int'(got_q[0]), int'({1'b1, 1'b0, 8'd35}));
      chk("t2_kept1", int'(got_q[1]), int'({1'b0, 1'b0, 8'd55}));
    end
    chk("t2_empty", int'(ifb.out_valid), 0);
    clear_status = 1'b1; step(); clear_status = 1'b0;
    chk("t2_overflow_cleared", int'(ovf_b), 0);

    // Early eop, then clean frame, then frame missing its eop
    sel = 0;
    do_reset();
    sb_en = 1'b1; out_ready = 1'b1; got_q.delete();
    send_frame(7, 6);
    step(); step(); step();
    chk("t3_frame_err", int'(ferr_a), 1);
    chk("t3_partial_count", got_q.size(), 1);
    if (got_q.size() == 1) chk("t3_partial_word", int'(got_q[0]), int'({1'b1, 1'b0, 8'd35}));
    clear_status = 1'b1; step(); clear_status = 1'b0;
    chk("t3_err_cleared", int'(ferr_a), 0);
    for (int i = 0; i < 16; i++) frame_px[i] = 8'(i * 13 + 7);
    send_frame(16, 15);
    drain();
    chk("t3_clean_no_err", int'(ferr_a), 0);
    got_q.delete();
    send_frame(16, -1);
    drain();
    chk("t3_missing_eop_err", int'(ferr_a), 1);
    if (got_q.size() > 0) chk("t3_missing_eop_still_eop", int'(got_q[$][8]), 1);
    else chk("t3_missing_eop_outputs", 0, 4);

    // sop arriving mid-frame
    sb_en = 1'b0;
    do_reset();
    sb_en = 1'b1; got_q.delete();
    load_t1();
    send_frame(9, -1);
    send_frame(16, 15);
    drain();
    chk("t4_frame_err", int'(ferr_a), 1);
    chk("t4_count", got_q.size(), 6);
    if (got_q.size() == 6) chk("t4_restart_sop", int'(got_q[2]), int'({1'b1, 1'b0, 8'd35}));

    // Beats before sop ignored; reset mid-frame
    sb_en = 1'b0;
    do_reset();
    sb_en = 1'b1; out_ready = 1'b0; got_q.delete();
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_data = 8'(200 + i); in_sop = 1'b0; in_eop = (i == 1);
      step();
    end
    load_t1();
    send_frame(10, -1);
    send_frame(3, -1);
    step();
    chk("t5_err_before_rst", int'(ferr_a), 1);
    chk("t5_valid_before_rst", int'(ifa.out_valid), 1);
    rst = 1'b1;
    step();
    chk("t5_valid_after_rst", int'(ifa.out_valid), 0);
    chk("t5_err_after_rst", int'(ferr_a), 0);
    rst = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 16; i++) frame_px[i] = 8'(255 - i * 9);
    send_frame(16, 15);
    drain();

    // Larger frame, random data, random ready, input gaps
    sb_en = 1'b0; sel = 2;
    do_reset();
    sb_en = 1'b1; gaps = 1'b1; rnd_ready = 1'b1;
    for (int f = 0; f < 2; f++) begin
      for (int i = 0; i < 48; i++) frame_px[i] = 8'($urandom_range(0, 255));
      send_frame(48, 47);
    end
    drain();
    rnd_ready = 1'b0; gaps = 1'b0;
    chk("t6_no_overflow", int'(ovf_c), 0);
    chk("t6_no_frame_err", int'(ferr_c), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
